// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI definitions for the note controller slice.
//   - status-nibble constants for the channel-voice message types
//   - controller numbers for the "all notes off" family
//   - parser state enum and internal note-action enum
//   - setpoint width and a helper that sizes channel-voice messages
// Optional feature elsewhere in the slice: MIDI_ALL_NOTES_OFF_EN.
package midi_pkg;

  localparam int SP_W = 22;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHPRESS  = 4'hD;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [2:0] {
    IDLE,
    DATA1,
    DATA2,
    SKIP1,
    SKIP2
  } parse_state_t;

  typedef enum logic [1:0] {
    ACT_ON,
    ACT_OFF,
    ACT_ALL_OFF
  } note_act_t;

  // Program change and channel pressure carry a single data byte;
  // every other channel-voice message carries two.
  function automatic logic one_data_byte(input logic [3:0] kind);
    return (kind == PROG) || (kind == CHPRESS);
  endfunction

endpackage

// File: rtl/midi_note_ctrl_if.sv
// midi_note_ctrl_if: byte-stream input and voice outputs of one MIDI voice.
//   rx_data  [7:0]      received MIDI byte
//   rx_valid            one-cycle strobe, rx_data valid this cycle
//   enable              voice on
//   setpoint [SP_W-1:0] half-period in int_clk cycles
//   note     [6:0]      currently sounding note number
// Modports: master drives the byte stream, slave is the voice controller.
interface midi_note_ctrl_if;
  import midi_pkg::*;

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            enable;
  logic [SP_W-1:0] setpoint;
  logic [6:0]      note;

  modport master (
    output rx_data,
    output rx_valid,
    input  enable,
    input  setpoint,
    input  note
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output enable,
    output setpoint,
    output note
  );

endinterface

// File: rtl/midi_note_rom.sv
// midi_note_rom: 128-entry note-number to half-period lookup.
//   int_clk        clock
//   addr  [6:0]    MIDI note number
//   data  [SP_W-1:0] round(CLK_HZ / (2 * f(addr))), registered (1-cycle latency)
// f(n) = 440 * 2^((n-69)/12). The table is built at elaboration from CLK_HZ,
// so the same ROM can be shared by other voices running off any clock.
module midi_note_rom
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000
) (
  input  logic            int_clk,
  input  logic [6:0]      addr,
  output logic [SP_W-1:0] data
);

  // Elaboration-time only; values saturate rather than wrap if a faster
  // clock ever pushes the lowest notes past the setpoint width.
  function automatic logic [SP_W-1:0] note_period(input int n);
    real freq;
    real period;
    int  rounded;
    freq   = 440.0 * $pow(2.0, (n - 69) / 12.0);
    period = CLK_HZ / (2.0 * freq);
    if (period >= 4194303.0) begin
      return '1;
    end
    rounded = $rtoi(period + 0.5);
    return rounded[SP_W-1:0];
  endfunction

  logic [SP_W-1:0] table_w [128];

  for (genvar i = 0; i < 128; i++) begin : g_entry
    localparam logic [SP_W-1:0] PERIOD = note_period(i);
    assign table_w[i] = PERIOD;
  end

  always_ff @(posedge int_clk) begin
    data <= table_w[addr];
  end

endmodule

// File: rtl/midi_note_ctrl.sv
// midi_note_ctrl: monophonic MIDI front end for one floppy voice.
//   int_clk   clock
//   rst       asynchronous, active-high reset
//   bus       midi_note_ctrl_if.slave
//               rx_data/rx_valid  received byte stream from the UART
//               enable            voice on (floppy enable)
//               setpoint          half-period in int_clk cycles
//               note              currently sounding note
// Parses channel-voice messages for CHANNEL with running status, applies
// note-on/off with last-note priority, and updates the outputs two edges
// after the edge that samples the final data byte.
// Optional: define MIDI_ALL_NOTES_OFF_EN so that CC 120/123 on CHANNEL
// silence the voice.
module midi_note_ctrl
  import midi_pkg::*;
#(
  parameter int CHANNEL  = 0,
  parameter int CLK_HZ   = 50000000,
  parameter int NOTE_MIN = 24,
  parameter int NOTE_MAX = 96
) (
  input  logic              int_clk,
  input  logic              rst,
  midi_note_ctrl_if.slave   bus
);

  localparam logic [3:0] CH    = CHANNEL[3:0];
  localparam logic [6:0] N_MIN = NOTE_MIN[6:0];
  localparam logic [6:0] N_MAX = NOTE_MAX[6:0];

  parse_state_t state;
  logic [7:0]   run_status;
  logic [6:0]   data1;

  // stage 0: decoded action, also the ROM address
  logic         act_valid;
  note_act_t    act_kind;
  logic [6:0]   act_note;

  // stage 1: aligned with the ROM output
  logic         s1_valid;
  note_act_t    s1_kind;
  logic [6:0]   s1_note;
  logic [SP_W-1:0] rom_data;

  logic [3:0]   kind;
  logic [6:0]   rx_low;

  assign kind   = run_status[7:4];
  assign rx_low = bus.rx_data[6:0];

  // True for statuses whose data bytes this voice must actually parse.
  function automatic logic tracked(input logic [7:0] status);
    logic hit;
    hit = (status[3:0] == CH) &&
          ((status[7:4] == NOTE_ON) || (status[7:4] == NOTE_OFF));
`ifdef MIDI_ALL_NOTES_OFF_EN
    if ((status[3:0] == CH) && (status[7:4] == CTRL)) begin
      hit = 1'b1;
    end
`endif
    return hit;
  endfunction

  // Parser. Running status holds the last channel-voice status (tracked or
  // not), so a bare data byte in IDLE restarts that message; 0 means none.
  // Status bytes always win, which is what aborts a partial message.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      run_status <= 8'h00;
      data1      <= 7'd0;
      act_valid  <= 1'b0;
      act_kind   <= ACT_ON;
      act_note   <= 7'd0;
    end else begin
      act_valid <= 1'b0;
      if (bus.rx_valid) begin
        if (bus.rx_data >= 8'hF8) begin
          state <= state;
        end else if (bus.rx_data >= 8'hF0) begin
          run_status <= 8'h00;
          state      <= IDLE;
        end else if (bus.rx_data[7]) begin
          run_status <= bus.rx_data;
          if (tracked(bus.rx_data)) begin
            state <= DATA1;
          end else if (one_data_byte(bus.rx_data[7:4])) begin
            state <= SKIP1;
          end else begin
            state <= SKIP2;
          end
        end else begin
          case (state)
            IDLE: begin
              if (run_status[7]) begin
                data1 <= rx_low;
                if (tracked(run_status)) begin
                  state <= DATA2;
                end else if (one_data_byte(kind)) begin
                  state <= IDLE;
                end else begin
                  state <= SKIP1;
                end
              end
            end
            DATA1: begin
              data1 <= rx_low;
              state <= DATA2;
            end
            DATA2: begin
              state    <= IDLE;
              act_note <= data1;
              if ((kind == NOTE_ON) && (rx_low != 7'd0)) begin
                if ((data1 >= N_MIN) && (data1 <= N_MAX)) begin
                  act_valid <= 1'b1;
                  act_kind  <= ACT_ON;
                end
              end else if ((kind == NOTE_ON) || (kind == NOTE_OFF)) begin
                act_valid <= 1'b1;
                act_kind  <= ACT_OFF;
              end
`ifdef MIDI_ALL_NOTES_OFF_EN
              else if ((kind == CTRL) &&
                       ((data1 == CC_ALL_SOUND_OFF) ||
                        (data1 == CC_ALL_NOTES_OFF))) begin
                act_valid <= 1'b1;
                act_kind  <= ACT_ALL_OFF;
              end
`endif
            end
            SKIP1:   state <= IDLE;
            SKIP2:   state <= SKIP1;
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  midi_note_rom #(
    .CLK_HZ (CLK_HZ)
  ) u_rom (
    .int_clk (int_clk),
    .addr    (act_note),
    .data    (rom_data)
  );

  // Action pipeline plus output register. The action travels alongside the
  // ROM read so note, setpoint and enable change on the same edge, and every
  // action follows the same path so ordering is preserved. Note-off is
  // matched against the registered outputs at apply time.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_kind      <= ACT_ON;
      s1_note      <= 7'd0;
      bus.enable   <= 1'b0;
      bus.setpoint <= {SP_W{1'b1}};
      bus.note     <= 7'd0;
    end else begin
      s1_valid <= act_valid;
      s1_kind  <= act_kind;
      s1_note  <= act_note;
      if (s1_valid) begin
        case (s1_kind)
          ACT_ON: begin
            bus.enable   <= 1'b1;
            bus.setpoint <= rom_data;
            bus.note     <= s1_note;
          end
          ACT_OFF: begin
            if (bus.enable && (bus.note == s1_note)) begin
              bus.enable <= 1'b0;
            end
          end
          ACT_ALL_OFF: bus.enable <= 1'b0;
          default:     bus.enable <= bus.enable;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_midi_note_ctrl.sv
// tb_midi_note_ctrl: self-checking bench for midi_note_ctrl.
// A message-level reference model (running status plus a data-byte count
// per message type) predicts enable/setpoint/note; the prediction is delayed
// by two clock edges and compared with the DUT after every edge. Directed
// steps follow, then a randomized byte stream.
// Honours MIDI_ALL_NOTES_OFF_EN for the control-change expectations.
module tb_midi_note_ctrl;
  import midi_pkg::*;

  localparam int CHANNEL  = 0;
  localparam int CLK_HZ   = 50000000;
  localparam int NOTE_MIN = 24;
  localparam int NOTE_MAX = 96;

  logic int_clk = 1'b0;
  logic rst     = 1'b1;

  midi_note_ctrl_if bus ();

  midi_note_ctrl #(
    .CHANNEL  (CHANNEL),
    .CLK_HZ   (CLK_HZ),
    .NOTE_MIN (NOTE_MIN),
    .NOTE_MAX (NOTE_MAX)
  ) dut (
    .int_clk (int_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 int_clk = ~int_clk;

  typedef struct packed {
    logic        en;
    logic [21:0] sp;
    logic [6:0]  nt;
  } snap_t;

  localparam snap_t RESET_SNAP = '{en: 1'b0, sp: 22'h3FFFFF, nt: 7'd0};

  snap_t      mdl;
  snap_t      p1;
  snap_t      p2;
  logic [7:0] run_st;
  int         got;
  logic [6:0] m0;
  int         total = 0;
  int         bad   = 0;

  logic [7:0] st_pool [12] = '{8'h90, 8'h90, 8'h80, 8'hB0, 8'hC0, 8'hD0,
                               8'hE0, 8'hA0, 8'h91, 8'h81, 8'hF0, 8'hF7};

  function automatic logic [21:0] ref_period(input int n);
    real hz;
    int  v;
    hz = 440.0 * $pow(2.0, real'(n - 69) / 12.0);
    v  = $rtoi(real'(CLK_HZ) / (2.0 * hz) + 0.5);
    return v[21:0];
  endfunction

  function automatic int msg_len(input logic [7:0] st);
    return ((st[7:4] == 4'hC) || (st[7:4] == 4'hD)) ? 1 : 2;
  endfunction

  function automatic void model_reset();
    mdl    = RESET_SNAP;
    p1     = RESET_SNAP;
    p2     = RESET_SNAP;
    run_st = 8'h00;
    got    = 0;
    m0     = 7'd0;
  endfunction

  function automatic void model_apply(input logic [7:0] st, input logic [6:0] d0,
                                      input logic [6:0] d1);
    if (st[3:0] != CHANNEL[3:0]) return;
    case (st[7:4])
      4'h9: begin
        if (d1 != 7'd0) begin
          if ((int'(d0) >= NOTE_MIN) && (int'(d0) <= NOTE_MAX)) begin
            mdl.en = 1'b1;
            mdl.nt = d0;
            mdl.sp = ref_period(int'(d0));
          end
        end else if (mdl.en && (mdl.nt == d0)) begin
          mdl.en = 1'b0;
        end
      end
      4'h8: begin
        if (mdl.en && (mdl.nt == d0)) mdl.en = 1'b0;
      end
      4'hB: begin
`ifdef MIDI_ALL_NOTES_OFF_EN
        if ((d0 == 7'd120) || (d0 == 7'd123)) mdl.en = 1'b0;
`endif
      end
      default: ;
    endcase
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (b >= 8'hF8) return;
    if (b >= 8'hF0) begin
      run_st = 8'h00;
      got    = 0;
      return;
    end
    if (b[7]) begin
      run_st = b;
      got    = 0;
      return;
    end
    if (run_st == 8'h00) return;
    if (msg_len(run_st) == 1) begin
      model_apply(run_st, b[6:0], 7'd0);
    end else if (got == 0) begin
      m0  = b[6:0];
      got = 1;
    end else begin
      model_apply(run_st, m0, b[6:0]);
      got = 0;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock with an optional byte; the DUT is compared with the model
  // state from two edges earlier.
  task automatic tick(input logic valid, input logic [7:0] b);
    snap_t exp;
    @(negedge int_clk);
    bus.rx_valid = valid;
    bus.rx_data  = b;
    @(posedge int_clk);
    if (valid) model_byte(b);
    exp = p2;
    p2  = p1;
    p1  = mdl;
    #1;
    bus.rx_valid = 1'b0;
    checkOutput("cyc_enable", {31'd0, bus.enable}, {31'd0, exp.en});
    checkOutput("cyc_setpoint", {10'd0, bus.setpoint}, {10'd0, exp.sp});
    checkOutput("cyc_note", {25'd0, bus.note}, {25'd0, exp.nt});
  endtask

  task automatic applyStimulus(input logic [7:0] b);
    tick(1'b1, b);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_enable"}, {31'd0, bus.enable}, 32'd0);
    checkOutput({tag, "_setpoint"}, {10'd0, bus.setpoint}, 32'h003FFFFF);
    checkOutput({tag, "_note"}, {25'd0, bus.note}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;

    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    model_reset();
    repeat (3) @(posedge int_clk);
    #1;
    checkReset("reset");
    @(negedge int_clk);
    rst = 1'b0;
    $display("[TB] reset released");

    // Basic note-on: A4
    applyStimulus(8'h90);
    applyStimulus(8'h45);
    applyStimulus(8'h64);
    idle(3);
    checkOutput("on69_enable", {31'd0, bus.enable}, 32'd1);
    checkOutput("on69_note", {25'd0, bus.note}, 32'd69);
    checkOutput("on69_setpoint", {10'd0, bus.setpoint}, 32'd56818);

    // Running status: replace with A5 back to back, then release with vel 0
    applyStimulus(8'h51);
    applyStimulus(8'h40);
    idle(3);
    checkOutput("on81_note", {25'd0, bus.note}, 32'd81);
    checkOutput("on81_setpoint", {10'd0, bus.setpoint}, 32'd28409);
    applyStimulus(8'h51);
    applyStimulus(8'h00);
    idle(3);
    checkOutput("off81_enable", {31'd0, bus.enable}, 32'd0);
    checkOutput("off81_setpoint", {10'd0, bus.setpoint}, 32'd28409);

    // Non-matching note-off and other-channel traffic
    applyStimulus(8'h90); applyStimulus(8'h45); applyStimulus(8'h64);
    applyStimulus(8'h80); applyStimulus(8'h48); applyStimulus(8'h40);
    applyStimulus(8'h91); applyStimulus(8'h3C); applyStimulus(8'h64);
    idle(3);
    checkOutput("nomatch_enable", {31'd0, bus.enable}, 32'd1);
    checkOutput("nomatch_note", {25'd0, bus.note}, 32'd69);

    // Realtime interleaved, program change, out-of-range note
    applyStimulus(8'h90); applyStimulus(8'hF8);
    applyStimulus(8'h3C); applyStimulus(8'hF8);
    applyStimulus(8'h7F); applyStimulus(8'hF8);
    applyStimulus(8'hC0); applyStimulus(8'h05);
    applyStimulus(8'h90); applyStimulus(8'h10); applyStimulus(8'h40);
    idle(3);
    checkOutput("rt_note", {25'd0, bus.note}, 32'd60);
    checkOutput("rt_enable", {31'd0, bus.enable}, 32'd1);

    // Reset between the two data bytes of a note-on
    applyStimulus(8'h90);
    applyStimulus(8'h3E);
    @(negedge int_clk);
    rst = 1'b1;
    #1;
    checkReset("midrst");
    model_reset();
    @(negedge int_clk);
    rst = 1'b0;
    applyStimulus(8'h40);
    applyStimulus(8'h40);
    idle(3);
    checkReset("postrst");

    // Control change 123 while sounding
    applyStimulus(8'h90); applyStimulus(8'h45); applyStimulus(8'h64);
    idle(3);
    applyStimulus(8'hB0); applyStimulus(8'h7B); applyStimulus(8'h00);
    idle(3);
`ifdef MIDI_ALL_NOTES_OFF_EN
    checkOutput("cc123_enable", {31'd0, bus.enable}, 32'd0);
`else
    checkOutput("cc123_enable", {31'd0, bus.enable}, 32'd1);
`endif

    // Randomized byte stream
    $display("[TB] random stream");
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 14) begin
        b = st_pool[$urandom_range(0, 11)];
      end else if (r < 18) begin
        b = 8'hF8 + 8'($urandom_range(0, 7));
      end else if (r < 28) begin
        b = 8'($urandom_range(0, 127));
      end else if (r < 34) begin
        b = 8'h00;
      end else begin
        b = 8'($urandom_range(16, 104));
      end
      applyStimulus(b);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
